// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says game blocks.
// Colours map one-to-one onto the four game LEDs.
package simon_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } colour_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        PULSE_ON,
        PULSE_OFF,
        NEXT,
        DONE
    } player_state_t;

    function automatic logic [3:0] colour_to_led(input colour_t colour);
        case (colour)
            GREEN:   return 4'b0001;
            RED:     return 4'b0010;
            YELLOW:  return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    // Faster levels halve the window; never let it collapse to zero ticks.
    function automatic logic [15:0] scale_ticks(input logic [15:0] base,
                                                input logic [1:0]  speed);
        logic [15:0] scaled;
        scaled = base >> speed;
        return (scaled == 16'd0) ? 16'd1 : scaled;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter with a TICK_DIV prescaler; expired is high on the
// last cycle of a window lasting ticks*TICK_DIV cycles after load.
module tick_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] ticks,
    output logic        expired
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_d, presc_q;
    logic [15:0]   tick_d,  tick_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        presc_d = presc_q;
        tick_d  = tick_q;
        if (load) begin
            presc_d = PRESC_MAX;
            tick_d  = ticks - 16'd1;
        end else if (presc_q != '0) begin
            presc_d = presc_q - 1'b1;
        end else if (tick_q != '0) begin
            presc_d = PRESC_MAX;
            tick_d  = tick_q - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            presc_q <= '0;
            tick_q  <= '0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    assign expired = (presc_q == '0) && (tick_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Plays the stored colour sequence on the game LEDs during the computer's
// turn: fetch a colour, light it for the on-window, then hold a dark gap.
module sequence_player
    import simon_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int BASE_ON_TICKS  = 400,
    parameter int BASE_OFF_TICKS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [5:0] round_len,
    input  logic [1:0] speed,
    output logic       mem_rd,
    output logic [5:0] mem_addr,
    input  logic [1:0] mem_data,
    output logic [3:0] led,
    output logic       busy,
    output logic       done
);

    player_state_t state_d, state_q;
    logic [5:0]    len_d, len_q;
    logic [5:0]    idx_d, idx_q;
    logic [15:0]   on_ticks_d, on_ticks_q;
    logic [15:0]   off_ticks_d, off_ticks_q;
    colour_t       colour_d, colour_q;
    logic [3:0]    led_d, led_q;
    logic          mem_rd_d, mem_rd_q;
    logic [5:0]    mem_addr_d, mem_addr_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;

    logic          timer_load;
    logic [15:0]   timer_ticks;
    logic          timer_expired;

    // One timer serves both windows: reload on entry to PULSE_ON and PULSE_OFF.
    assign timer_load  = (state_q == WAIT_DATA) || ((state_q == PULSE_ON) && timer_expired);
    assign timer_ticks = (state_q == WAIT_DATA) ? on_ticks_q : off_ticks_q;

    tick_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (timer_load),
        .ticks   (timer_ticks),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        idx_d       = idx_q;
        on_ticks_d  = on_ticks_q;
        off_ticks_d = off_ticks_q;
        colour_d    = colour_q;
        led_d       = led_q;
        mem_rd_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (round_len != 6'd0) begin
                        len_d       = round_len;
                        on_ticks_d  = scale_ticks(16'(BASE_ON_TICKS), speed);
                        off_ticks_d = scale_ticks(16'(BASE_OFF_TICKS), speed);
                        idx_d       = 6'd0;
                        mem_rd_d    = 1'b1;
                        mem_addr_d  = 6'd0;
                        busy_d      = 1'b1;
                        state_d     = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            FETCH: state_d = WAIT_DATA;
            WAIT_DATA: begin
                colour_d = colour_t'(mem_data);
                led_d    = colour_to_led(colour_t'(mem_data));
                state_d  = PULSE_ON;
            end
            PULSE_ON: begin
                led_d = colour_to_led(colour_q);
                if (timer_expired) begin
                    led_d   = 4'b0000;
                    state_d = PULSE_OFF;
                end
            end
            PULSE_OFF: begin
                if (timer_expired) state_d = NEXT;
            end
            NEXT: begin
                if (idx_q == len_q - 6'd1) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + 6'd1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = idx_q + 6'd1;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            state_d  = IDLE;
            idx_d    = 6'd0;
            led_d    = 4'b0000;
            mem_rd_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= 6'd0;
            idx_q       <= 6'd0;
            on_ticks_q  <= 16'd0;
            off_ticks_q <= 16'd0;
            colour_q    <= GREEN;
            led_q       <= 4'b0000;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= 6'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            on_ticks_q  <= on_ticks_d;
            off_ticks_q <= off_ticks_d;
            colour_q    <= colour_d;
            led_q       <= led_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign led      = led_q;
    assign mem_rd   = mem_rd_q;
    assign mem_addr = mem_addr_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
